apb_req_arbiter: RTL
====================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 8'd255, ACCESS-wait cycle limit, used only when APB_ARB_TIMEOUT_EN is defined.
REQ-002 PCLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 PRESETn  input  1  reset, asynchronous assert, active-low.
REQ-004 REQ  input  4  per-requester transfer request, level, held until ACK.
REQ-005 REQ_WRITE  input  4  per-requester direction: 1 = write, 0 = read.
REQ-006 REQ_ADDR  input  128  four packed 32-bit addresses; requester n at bits [32n+31:32n].
REQ-007 REQ_WDATA  input  128  four packed 32-bit write data words, same packing.
REQ-008 ACK  output  4  one-cycle completion pulse to the granted requester.
REQ-009 RDATA  output  32  read data captured at completion; held until next completion.
REQ-010 RERR  output  1  error flag captured at completion, valid with ACK.
REQ-011 TRANSFER  output  1  transfer strobe to the APB master.
REQ-012 READ_WRITE  output  1  direction to the APB master.
REQ-013 PADDR_IN  output  32  address to the APB master.
REQ-014 PWDATA_IN  output  32  write data to the APB master.
REQ-015 PENABLE, PREADY, PSLVERR  input  1 each  bus phase observation; PREADY is the OR of the slave readies.
REQ-016 PRDATA  input  32  bus read data.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-018 IDLE: if REQ != 0, grant the round-robin winner, latch its WRITE/ADDR/WDATA, and go to ISSUE; otherwise stay in IDLE.
REQ-019 Round-robin order: search starts at (last_grant+1) mod 4 and wraps; last_grant updates on each grant.
REQ-020 ISSUE lasts exactly one cycle with TRANSFER=1, then the FSM goes to WAIT.
REQ-021 TRANSFER SHALL be 0 in every state except ISSUE, so the master returns to idle after each transfer (no back-to-back chaining).
REQ-022 READ_WRITE, PADDR_IN and PWDATA_IN SHALL drive the latched values from ISSUE through DONE without change.
REQ-023 WAIT: on a cycle with PENABLE=1 and PREADY=1, capture PRDATA into RDATA (reads only; writes leave RDATA unchanged), capture PSLVERR into RERR, and go to DONE.
REQ-024 DONE lasts one cycle with ACK[grant]=1 and all other ACK bits 0, then the FSM goes to IDLE.
REQ-025 A request raised or changed while the FSM is outside IDLE has no effect until the next IDLE arbitration.
REQ-026 A requester that drops REQ before it is granted is not serviced.
REQ-027 Grant-to-ACK latency is 2 + (number of WAIT cycles); the minimum is 4 cycles from the IDLE sample to the ACK pulse.
REQ-028 The arbiter returns to IDLE for one cycle between consecutive transfers.

Reset
REQ-029 While PRESETn=0, and asynchronously on its assertion, the block SHALL hold: state=IDLE, ACK=0, RDATA=0, RERR=0, TRANSFER=0, READ_WRITE=0, PADDR_IN=0, PWDATA_IN=0, last_grant=3 (requester 0 wins first), timeout counter=0.
REQ-030 Reset asserted mid-transfer SHALL abandon the transfer with no ACK.
REQ-031 Release is sampled synchronously: the first arbitration occurs on the first rising edge with PRESETn=1.

Configuration
REQ-032 Macro APB_ARB_TIMEOUT_EN defined: an 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
REQ-033 With APB_ARB_TIMEOUT_EN, reaching TIMEOUT without completion forces DONE with RERR=1 and RDATA unchanged.
REQ-034 Macro not defined: no counter is built, WAIT persists indefinitely, and the TIMEOUT parameter is unused.

Verification
REQ-035 Reset, then REQ=4'b0001, write, addr 0x04, data 0xA5A5A5A5 -> one TRANSFER pulse, PADDR_IN=0x04 held, ACK=4'b0001 once, RERR=0.
REQ-036 REQ=4'b1111 held continuously, zero-wait slaves -> grant order 0,1,2,3,0, one ACK per transfer, no starvation.
REQ-037 Read addr 0x18, PREADY low 3 cycles in ACCESS, PRDATA=0x12345678 -> RDATA=0x12345678 with ACK, latency 7 cycles.
REQ-038 PSLVERR=1 at completion -> RERR=1 with ACK; the next clean transfer returns RERR=0.
REQ-039 PRESETn pulsed low during WAIT -> all outputs 0 immediately, no ACK, and the next grant goes to requester 0.
REQ-040 With APB_ARB_TIMEOUT_EN, TIMEOUT=4, PREADY stuck low -> ACK with RERR=1 after 4 WAIT cycles; without the macro -> no ACK.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// Four-requester round-robin front end for an APB master: one transfer at a time.
// Optional ACCESS-wait timeout is built only when APB_ARB_TIMEOUT_EN is defined.
module apb_req_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic         PCLK,
  input  logic         PRESETn,
  input  logic [3:0]   REQ,
  input  logic [3:0]   REQ_WRITE,
  input  logic [127:0] REQ_ADDR,
  input  logic [127:0] REQ_WDATA,
  output logic [3:0]   ACK,
  output logic [31:0]  RDATA,
  output logic         RERR,
  output logic         TRANSFER,
  output logic         READ_WRITE,
  output logic [31:0]  PADDR_IN,
  output logic [31:0]  PWDATA_IN,
  input  logic         PENABLE,
  input  logic         PREADY,
  input  logic         PSLVERR,
  input  logic [31:0]  PRDATA
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        rw_q, rw_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rerr_q, rerr_d;
  logic [1:0]  win;

`ifdef APB_ARB_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
`else
  // TIMEOUT has no effect in this build.
  if (TIMEOUT == 8'd0) begin : g_timeout_unused
  end
`endif

  // Search starts just after the last grant; the last grant itself is tried last.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found = 1'b0;
    win   = grant_q;
    idx   = grant_q;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = 2'(grant_q + 2'(i));
      if (!found && REQ[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|REQ) begin
          grant_d = win;
          rw_d    = REQ_WRITE[win];
          addr_d  = REQ_ADDR[{win, 5'd0} +: 32];
          wdata_d = REQ_WDATA[{win, 5'd0} +: 32];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (PENABLE && PREADY) begin
          if (!rw_q) rdata_d = PRDATA;
          rerr_d  = PSLVERR;
          ack_d   = 4'b0001 << grant_q;
          state_d = S_DONE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (cnt_q + 8'd1 == TIMEOUT) begin
          rerr_d  = 1'b1;
          ack_d   = 4'b0001 << grant_q;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= S_IDLE;
      grant_q <= 2'd3;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`endif

  assign TRANSFER   = (state_q == S_ISSUE);
  assign READ_WRITE = rw_q;
  assign PADDR_IN   = addr_q;
  assign PWDATA_IN  = wdata_q;
  assign ACK        = ack_q;
  assign RDATA      = rdata_q;
  assign RERR       = rerr_q;

endmodule
